// File: rtl/pong_game_ctrl_if.sv
// pong_game_ctrl_if: control/status bundle between the pong game-flow controller and the rest of the pong design.
interface pong_game_ctrl_if;
   logic       frame_tick;
   logic       btn_launch;
   logic       btn_up;
   logic       btn_down;
   logic       hit_left;
   logic       hit_right;
   logic [2:0] state;
   logic [4:0] score_p1;
   logic [4:0] score_p2;
   logic [4:0] max_score;
   logic       serve_side;
   logic       serve_pulse;
   logic       winner;
   modport master (
      output frame_tick, btn_launch, btn_up, btn_down, hit_left, hit_right,
      input  state, score_p1, score_p2, max_score, serve_side, serve_pulse, winner
   );
   modport slave (
      input  frame_tick, btn_launch, btn_up, btn_down, hit_left, hit_right,
      output state, score_p1, score_p2, max_score, serve_side, serve_pulse, winner
   );
endinterface

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: debounced game-flow FSM (menu, target score, serve, scoring, game end) in the clk_pix domain.
// Define PONG_AUTO_SERVE_EN to serve automatically after SERVE_TIMEOUT_FRAMES idle frames in START.
module pong_game_ctrl #(
   parameter int DEFAULT_MAX_SCORE    = 5,
   parameter int MAX_SCORE_LIMIT      = 21,
   parameter int DEBOUNCE_FRAMES      = 3,
   parameter int POINT_HOLD_FRAMES    = 60,
   parameter int SERVE_TIMEOUT_FRAMES = 180
) (
   input logic             clk_pix,
   input logic             reset,
   pong_game_ctrl_if.slave bus
);
   localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
   localparam int FW = $clog2((POINT_HOLD_FRAMES > SERVE_TIMEOUT_FRAMES ? POINT_HOLD_FRAMES : SERVE_TIMEOUT_FRAMES) + 1);
   typedef enum logic [2:0] {MENU, SET, START, PLAY, END_POINT, END_GAME} state_t;
   logic [2:0]    btn, press;
   logic [DW-1:0] db_cnt [3];
   state_t        state_q, state_d;
   logic [4:0]    p1_q, p1_d, p2_q, p2_d, max_q, max_d;
   logic          side_q, side_d, win_q, win_d, sp_q, sp_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          launch, up, down, go_serve;
   assign btn = {bus.btn_down, bus.btn_up, bus.btn_launch};
   assign {down, up, launch} = press;
   // press fires on the tick that brings the counter to DEBOUNCE_FRAMES; saturation blocks repeats
   always_ff @(posedge clk_pix) begin
      if (reset) begin
         press <= '0;
         for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            press[i] <= bus.frame_tick && btn[i] && db_cnt[i] == DW'(DEBOUNCE_FRAMES - 1);
            if (bus.frame_tick)
               db_cnt[i] <= !btn[i] ? '0 : db_cnt[i] == DW'(DEBOUNCE_FRAMES) ? db_cnt[i] : db_cnt[i] + 1'b1;
         end
      end
   end
`ifdef PONG_AUTO_SERVE_EN
   assign go_serve = launch || (bus.frame_tick && fcnt_q == FW'(SERVE_TIMEOUT_FRAMES - 1));
`else
   assign go_serve = launch;
`endif
   always_comb begin
      state_d = state_q;
      p1_d    = p1_q;
      p2_d    = p2_q;
      max_d   = max_q;
      side_d  = side_q;
      win_d   = win_q;
      sp_d    = 1'b0;
      case (state_q)
         MENU: if (launch) state_d = SET;
         SET: begin
            if (up && !down && max_q != 5'(MAX_SCORE_LIMIT)) max_d = max_q + 5'd1;
            if (down && !up && max_q != 5'd1) max_d = max_q - 5'd1;
            if (launch) begin
               state_d = START;
               p1_d    = '0;
               p2_d    = '0;
            end
         end
         START: if (go_serve) begin
            state_d = PLAY;
            sp_d    = 1'b1;
         end
         PLAY: begin
            if (bus.hit_right) begin
               p1_d    = p1_q + 5'd1;
               side_d  = 1'b1;
               state_d = END_POINT;
            end else if (bus.hit_left) begin
               p2_d    = p2_q + 5'd1;
               side_d  = 1'b0;
               state_d = END_POINT;
            end
         end
         END_POINT: if (bus.frame_tick && fcnt_q == FW'(POINT_HOLD_FRAMES - 1)) begin
            state_d = (p1_q == max_q || p2_q == max_q) ? END_GAME : START;
            win_d   = p1_q == max_q ? 1'b0 : p2_q == max_q ? 1'b1 : win_q;
         end
         END_GAME: if (launch) begin
            state_d = MENU;
            p1_d    = '0;
            p2_d    = '0;
         end
         default: state_d = MENU;
      endcase
      // frame counter restarts on every state change so END_POINT/START time from entry
      fcnt_d = state_d != state_q ? '0 : bus.frame_tick ? fcnt_q + 1'b1 : fcnt_q;
   end
   always_ff @(posedge clk_pix) begin
      if (reset) begin
         state_q <= MENU;
         p1_q    <= '0;
         p2_q    <= '0;
         max_q   <= 5'(DEFAULT_MAX_SCORE);
         side_q  <= 1'b0;
         win_q   <= 1'b0;
         sp_q    <= 1'b0;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         p1_q    <= p1_d;
         p2_q    <= p2_d;
         max_q   <= max_d;
         side_q  <= side_d;
         win_q   <= win_d;
         sp_q    <= sp_d;
         fcnt_q  <= fcnt_d;
      end
   end
   assign bus.state       = state_q;
   assign bus.score_p1    = p1_q;
   assign bus.score_p2    = p2_q;
   assign bus.max_score   = max_q;
   assign bus.serve_side  = side_q;
   assign bus.serve_pulse = sp_q;
   assign bus.winner      = win_q;
endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Game-flow controller for the VGA pong design.
- Sits upstream of the pixel renderer / ball engine.
- Consumes raw buttons, the per-frame animate tick and edge-hit pulses from the ball engine; produces the game state, scores, target score and serve side that the renderer and ball engine use.
- Replaces ad-hoc state, score and max-score logic with one synchronous FSM in the clk_pix domain.

Parameters:
- DEFAULT_MAX_SCORE, 5: target score loaded at reset.
- MAX_SCORE_LIMIT, 21: upper bound on target score; lower bound is fixed at 1.
- DEBOUNCE_FRAMES, 3: consecutive frame_tick samples a button must read high before it counts as pressed.
- POINT_HOLD_FRAMES, 60: frames spent in END_POINT before leaving it.
- SERVE_TIMEOUT_FRAMES, 180: auto-serve delay; used only with the optional feature.

Ports:
- clk_pix, in, 1: pixel clock; all logic is on its rising edge.
- reset, in, 1: synchronous, active-high.
- frame_tick, in, 1: one-cycle pulse per frame (y==480, x==0).
- btn_launch, in, 1: raw centre button.
- btn_up, in, 1: raw up button.
- btn_down, in, 1: raw down button.
- hit_left, in, 1: one-cycle pulse; ball reached the left goal.
- hit_right, in, 1: one-cycle pulse; ball reached the right goal.
- state, out, 3: 0 MENU, 1 SET, 2 START, 3 PLAY, 4 END_POINT, 5 END_GAME.
- score_p1, out, 5: left player score.
- score_p2, out, 5: right player score.
- max_score, out, 5: current target score.
- serve_side, out, 1: 0 = left player serves, 1 = right player serves.
- serve_pulse, out, 1: one-cycle pulse on the START->PLAY transition.
- winner, out, 1: 0 = p1, 1 = p2; valid only in END_GAME.

Behaviour:
- Reset (synchronous, active-high; clock clk_pix) values:
  - state=MENU, score_p1=0, score_p2=0, max_score=DEFAULT_MAX_SCORE.
  - serve_side=0, serve_pulse=0, winner=0.
  - All debounce and frame counters cleared.
  - Reset mid-game overrides every other event in that cycle.
- Debounce:
  - Each button is sampled only on frame_tick cycles.
  - A per-button counter increments while the sample is high and saturates at DEBOUNCE_FRAMES; it clears when the sample is low.
  - A press event is a one-cycle pulse in the clk_pix cycle where the counter first reaches DEBOUNCE_FRAMES.
  - A held button produces exactly one press event; the button must read low at one frame_tick before it can press again.
- FSM (registered; every transition takes effect on the clock edge after its cause):
  - MENU: launch press -> SET.
  - SET:
    - up press: max_score+1, saturating at MAX_SCORE_LIMIT.
    - down press: max_score-1, saturating at 1.
    - Simultaneous up and down presses: no change.
    - launch press -> START; score_p1 and score_p2 clear to 0 on the same edge.
  - START:
    - launch press -> PLAY; serve_pulse=1 for that one cycle.
    - up/down presses are ignored.
  - PLAY:
    - hit_right: score_p1+1, serve_side<=1, -> END_POINT.
    - hit_left: score_p2+1, serve_side<=0, -> END_POINT.
    - hit_left and hit_right in the same cycle: treated as hit_right only.
  - END_POINT:
    - Counts frame_ticks to POINT_HOLD_FRAMES; the count starts at 0 on entry.
    - On expiry, if score_p1==max_score: winner=0, -> END_GAME.
    - Else if score_p2==max_score: winner=1, -> END_GAME.
    - Else -> START.
  - END_GAME: launch press -> MENU; scores clear on this edge; max_score is retained.
- Hit pulses outside PLAY are ignored.
- Scores never exceed max_score, because a game ends on equality. A max_score change in SET always happens with scores at 0.
- A launch press consumed by one transition cannot also trigger the following state, because press events are single-cycle.
- States 6 and 7 are illegal; they return to MENU on the next edge.

Optional Feature:
- Macro: PONG_AUTO_SERVE_EN.
- Defined:
  - In START, a frame counter counts frame_ticks from entry.
  - When it reaches SERVE_TIMEOUT_FRAMES with no launch press, the FSM moves to PLAY and asserts serve_pulse exactly as a launch would.
  - A launch press before the timeout serves immediately.
  - The counter clears on every entry to START.
- Undefined: START waits indefinitely for a launch press; no auto-serve counter is synthesised.

Test Plan:
1. Reset, hold btn_launch high across 3 frame_ticks -> one press; state 0->1 exactly once; max_score=5, scores 0.
2. In SET, press up 20 times -> max_score saturates at 21. Press down 25 times -> max_score saturates at 1. Hold up and down together -> no change.
3. max_score=2; launch to START, launch to PLAY (serve_pulse high for 1 cycle). Pulse hit_right -> score_p1=1, serve_side=1, state=4. After 60 frame_ticks -> state=2.
4. Repeat: hit_right again -> score_p1=2; after hold -> state=5, winner=0. Launch -> state=0, scores 0, max_score still 2.
5. In PLAY, hit_left and hit_right in the same cycle -> score_p1 increments only, serve_side=1. Hit pulses in MENU/START -> no score change.
6. Reset asserted in PLAY with score_p2=3 -> next edge: state=0, scores 0, max_score=5. With PONG_AUTO_SERVE_EN defined, idle in START for 180 frame_ticks -> state=3, serve_pulse asserted.
